// File: rtl/rv_fetch_decode.sv
// rv_fetch_decode: front end of the RISC-V datapath.
// Owns the 8-bit PC, fetches one 32-bit word at a time over a req/ack
// memory port, splits it into decode fields and presents them to execute.
//
// Handshake semantics:
//   imem side : imem_req stays high (with imem_addr = pc) until the cycle
//               imem_ack pulses; imem_rdata is only looked at in that cycle.
//   exec side : dec_valid high means the field outputs are stable and will
//               stay stable until the cycle dec_valid && dec_ready, which is
//               the transfer; nothing changes on dec_ready alone.
//   redirect  : redirect_valid wins over both sides in the same cycle and
//               loads redirect_pc; an ack in that cycle is dropped, while a
//               transfer in that cycle still counts as retired.
module rv_fetch_decode #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  // instruction memory
  output logic             imem_req,
  output logic [7:0]       imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  // decoded instruction to execute
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [11:0]      imm,
  output logic [19:0]      uimm,
  output logic [7:0]       pc_out,
  output logic             illegal,
  // control flow change
  input  logic             redirect_valid,
  input  logic [7:0]       redirect_pc,
  // statistics and debug
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // Supported major opcodes.
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_pc;
  logic [31:0]      r_instr;
  logic [11:0]      r_imm;
  logic [19:0]      r_uimm;
  logic [7:0]       r_pc_out;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic [11:0]      w_imm;
  logic [19:0]      w_uimm;
  logic             w_illegal;
  logic             w_capture;
  logic             w_handshake;
  logic             w_cnt_full;

  // Immediate extraction and legality check straight from the memory word.
  always_comb begin
    w_imm     = 12'h000;
    w_uimm    = 20'h00000;
    w_illegal = 1'b0;
    case (imem_rdata[6:0])
      OP_IMM, OP_LOAD, OP_JALR: w_imm = imem_rdata[31:20];
      OP_STORE:  w_imm  = {imem_rdata[31:25], imem_rdata[11:7]};
      // Branch offset bit 0 is always zero, so the 12 bits start at bit 1.
      OP_BRANCH: w_imm  = {imem_rdata[31], imem_rdata[7],
                           imem_rdata[30:25], imem_rdata[11:8]};
      OP_LUI, OP_AUIPC: w_uimm = imem_rdata[31:12];
      // Jump offset bit 0 is also implicit.
      OP_JAL:    w_uimm = {imem_rdata[31], imem_rdata[19:12],
                           imem_rdata[20], imem_rdata[30:21]};
      OP_REG:    w_imm  = 12'h000;
      default:   w_illegal = 1'b1;
    endcase
  end

  // Qualified events: a usable fetch return and a completed transfer.
  always_comb begin
    w_capture   = (r_state == S_FETCH) && imem_ack && !redirect_valid;
    w_handshake = (r_state == S_OUT) && dec_ready;
    w_cnt_full  = &r_count;
  end

  // Next-state logic; a redirect always sends us back to fetching.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: if (imem_ack) w_next_state = S_OUT;
      S_OUT:   if (dec_ready) w_next_state = S_FETCH;
      default: w_next_state = S_IDLE;
    endcase
    if (redirect_valid) w_next_state = S_FETCH;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Program counter: redirect target beats the sequential increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_handshake) begin
      r_pc <= r_pc + 8'd4;
    end
  end

  // Decode field holding registers, loaded only on an accepted fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr   <= 32'h0;
      r_imm     <= 12'h000;
      r_uimm    <= 20'h00000;
      r_pc_out  <= 8'h00;
      r_illegal <= 1'b0;
    end else if (w_capture) begin
      r_instr   <= imem_rdata;
      r_imm     <= w_imm;
      r_uimm    <= w_uimm;
      r_pc_out  <= r_pc;
      r_illegal <= w_illegal;
    end
  end

  // Retired-instruction counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_handshake && !w_cnt_full) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Output drive: request/valid come from the state, fields from registers.
  always_comb begin
    imem_req    = (r_state == S_FETCH);
    imem_addr   = r_pc;
    dec_valid   = (r_state == S_OUT);
    opcode      = r_instr[6:0];
    rd          = r_instr[11:7];
    funct3      = r_instr[14:12];
    rs1         = r_instr[19:15];
    rs2         = r_instr[24:20];
    funct7      = r_instr[31:25];
    imm         = r_imm;
    uimm        = r_uimm;
    pc_out      = r_pc_out;
    illegal     = r_illegal;
    instr_count = r_count;
    dbg_state   = r_state;
  end

endmodule

// File: tb/tb_rv_fetch_decode.sv
// tb_rv_fetch_decode: directed bench with a transaction-level model and a
// per-cycle compare, plus literal checks on each directed vector.
module tb_rv_fetch_decode;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- main DUT (defaults) ----------------
  logic        imem_req, imem_ack, dec_valid, dec_ready, illegal, redirect_valid;
  logic [7:0]  imem_addr, pc_out, redirect_pc;
  logic [31:0] imem_rdata;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [11:0] imm;
  logic [19:0] uimm;
  logic [15:0] instr_count;
  logic [1:0]  dbg_state;

  rv_fetch_decode u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm(imm), .uimm(uimm), .pc_out(pc_out), .illegal(illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // ---------------- second DUT: reset PC FC, 2-bit counter ----------------
  logic        b_req, b_ack, b_valid, b_ready, b_illegal, b_redir;
  logic [7:0]  b_addr, b_pc_out, b_redir_pc;
  logic [31:0] b_rdata;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3;
  logic [11:0] b_imm;
  logic [19:0] b_uimm;
  logic [1:0]  b_count;
  logic [1:0]  b_state;

  rv_fetch_decode #(.RESET_PC(8'hFC), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack), .imem_rdata(b_rdata),
    .dec_valid(b_valid), .dec_ready(b_ready),
    .opcode(b_opcode), .rd(b_rd), .funct3(b_funct3), .rs1(b_rs1), .rs2(b_rs2), .funct7(b_funct7),
    .imm(b_imm), .uimm(b_uimm), .pc_out(b_pc_out), .illegal(b_illegal),
    .redirect_valid(b_redir), .redirect_pc(b_redir_pc),
    .instr_count(b_count), .dbg_state(b_state)
  );

  // ---------------- checking helpers ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm;
    logic [19:0] uimm;
    logic        illegal;
  } dec_t;

  // Decode following the ISA's own description: branch/jump offsets are
  // rebuilt as full byte offsets and then the implicit zero bit is dropped.
  function automatic dec_t model_decode(input logic [31:0] w);
    dec_t        d;
    logic [12:0] b_off;
    logic [20:0] j_off;
    d        = '0;
    d.opcode = w[6:0];
    d.rd     = w[11:7];
    d.funct3 = w[14:12];
    d.rs1    = w[19:15];
    d.rs2    = w[24:20];
    d.funct7 = w[31:25];
    b_off    = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j_off    = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    case (w[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: d.imm = w[31:20];
      7'b0100011: d.imm  = {w[31:25], w[11:7]};
      7'b1100011: d.imm  = b_off[12:1];
      7'b0110111, 7'b0010111: d.uimm = w[31:12];
      7'b1101111: d.uimm = j_off[20:1];
      7'b0110011: d.imm  = 12'h000;
      default:    d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  bit          m_fetch;
  bit          m_valid;
  logic [7:0]  m_pc;
  int unsigned m_count;
  dec_t        m_dec;
  logic [7:0]  exp_q[$];   // pc of the instruction currently being presented

  initial begin
    m_fetch = 0; m_valid = 0; m_pc = 8'h00; m_count = 0; m_dec = '0;
  end

  // Model advances on the same edge as the DUT, from the same inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_fetch = 0; m_valid = 0; m_pc = 8'h00; m_count = 0; m_dec = '0;
      exp_q.delete();
    end else begin
      if (m_valid && dec_ready && m_count < 65535) m_count++;
      if (redirect_valid) begin
        m_pc = redirect_pc;
        if (m_valid) void'(exp_q.pop_front());
        m_valid = 0;
        m_fetch = 1;
      end else if (m_fetch && imem_ack) begin
        m_dec = model_decode(imem_rdata);
        exp_q.push_back(m_pc);
        m_fetch = 0;
        m_valid = 1;
      end else if (m_valid && dec_ready) begin
        m_pc = m_pc + 8'd4;
        void'(exp_q.pop_front());
        m_valid = 0;
        m_fetch = 1;
      end else if (!m_valid && !m_fetch) begin
        m_fetch = 1;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetch});
    if (m_fetch) chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
    chk("dec_valid", {31'd0, dec_valid}, {31'd0, m_valid});
    chk("opcode", {25'd0, opcode}, {25'd0, m_dec.opcode});
    chk("rd", {27'd0, rd}, {27'd0, m_dec.rd});
    chk("funct3", {29'd0, funct3}, {29'd0, m_dec.funct3});
    chk("rs1", {27'd0, rs1}, {27'd0, m_dec.rs1});
    chk("rs2", {27'd0, rs2}, {27'd0, m_dec.rs2});
    chk("funct7", {25'd0, funct7}, {25'd0, m_dec.funct7});
    chk("imm", {20'd0, imm}, {20'd0, m_dec.imm});
    chk("uimm", {12'd0, uimm}, {12'd0, m_dec.uimm});
    chk("illegal", {31'd0, illegal}, {31'd0, m_dec.illegal});
    if (m_valid && exp_q.size() > 0) chk("pc_out", {24'd0, pc_out}, {24'd0, exp_q[0]});
    chk("instr_count", {16'd0, instr_count}, m_count);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_rdata = w;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic accept();
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    imem_ack = 0; imem_rdata = 32'h0; dec_ready = 0; redirect_valid = 0; redirect_pc = 8'h00;
    b_ack = 0; b_rdata = 32'h0; b_ready = 0; b_redir = 0; b_redir_pc = 8'h00;
    tick(); tick();

    // reset state
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    chk("rst_imm", {20'd0, imm}, 32'd0);

    rst = 1'b0;
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {24'd0, imem_addr}, 32'h00);
    chk("b_first_addr", {24'd0, b_addr}, 32'hFC);

    // ADDI x1,x0,5 on both DUTs
    b_rdata = 32'h00500093; b_ack = 1'b1;
    fetch(32'h00500093);
    b_ack = 1'b0;
    chk("addi_valid", {31'd0, dec_valid}, 32'd1);
    chk("addi_opcode", {25'd0, opcode}, 32'h13);
    chk("addi_rd", {27'd0, rd}, 32'd1);
    chk("addi_funct3", {29'd0, funct3}, 32'd0);
    chk("addi_rs1", {27'd0, rs1}, 32'd0);
    chk("addi_imm", {20'd0, imm}, 32'h005);
    chk("addi_illegal", {31'd0, illegal}, 32'd0);
    chk("addi_pc_out", {24'd0, pc_out}, 32'h00);
    chk("b_pc_out", {24'd0, b_pc_out}, 32'hFC);
    b_ready = 1'b1;
    accept();
    b_ready = 1'b0;
    chk("next_addr", {24'd0, imem_addr}, 32'h04);
    chk("count1", {16'd0, instr_count}, 32'd1);
    chk("b_wrap_addr", {24'd0, b_addr}, 32'h00);
    chk("b_count1", {30'd0, b_count}, 32'd1);

    // second DUT: counter saturates at 3
    for (int k = 2; k <= 5; k++) begin
      b_ack = 1'b1; tick(); b_ack = 1'b0;
      b_ready = 1'b1; tick(); b_ready = 1'b0;
      chk("b_count_sat", {30'd0, b_count}, (k > 3) ? 32'd3 : k);
    end

    // SUB x3,x1,x2 with a 5-cycle stall
    fetch(32'h402081B3);
    chk("sub_funct7", {25'd0, funct7}, 32'h20);
    chk("sub_rs2", {27'd0, rs2}, 32'd2);
    chk("sub_rs1", {27'd0, rs1}, 32'd1);
    chk("sub_rd", {27'd0, rd}, 32'd3);
    chk("sub_imm", {20'd0, imm}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_rd", {27'd0, rd}, 32'd3);
    end
    accept();
    chk("sub_next_req", {31'd0, imem_req}, 32'd1);
    chk("sub_next_addr", {24'd0, imem_addr}, 32'h08);
    chk("count2", {16'd0, instr_count}, 32'd2);

    // LUI x5,0x12345
    fetch(32'h123452B7);
    chk("lui_opcode", {25'd0, opcode}, 32'h37);
    chk("lui_rd", {27'd0, rd}, 32'd5);
    chk("lui_uimm", {12'd0, uimm}, 32'h12345);
    chk("lui_imm", {20'd0, imm}, 32'd0);
    accept();

    // BEQ, offset -4
    fetch(32'hFE000EE3);
    chk("beq_opcode", {25'd0, opcode}, 32'h63);
    chk("beq_imm", {20'd0, imm}, 32'hFFE);
    accept();

    // SW x2,8(x1)
    fetch(32'h0020A423);
    chk("sw_imm", {20'd0, imm}, 32'h008);
    chk("sw_funct3", {29'd0, funct3}, 32'd2);
    accept();

    // JAL x0,+8
    fetch(32'h0080006F);
    chk("jal_uimm", {12'd0, uimm}, 32'h00004);
    chk("jal_imm", {20'd0, imm}, 32'd0);
    accept();

    // illegal word; a stray ack while presenting must be ignored
    fetch(32'hFFFFFFFF);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_imm", {20'd0, imm}, 32'd0);
    chk("ill_uimm", {12'd0, uimm}, 32'd0);
    imem_rdata = 32'h00500093; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("stray_ack_opcode", {25'd0, opcode}, 32'h7F);
    chk("stray_ack_valid", {31'd0, dec_valid}, 32'd1);
    accept();
    chk("seq_addr", {24'd0, imem_addr}, 32'h1C);
    chk("count7", {16'd0, instr_count}, 32'd7);

    // redirect in FETCH with a simultaneous ack
    imem_rdata = 32'h00500093; imem_ack = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    chk("redir_fetch_valid", {31'd0, dec_valid}, 32'd0);
    chk("redir_fetch_addr", {24'd0, imem_addr}, 32'h40);
    fetch(32'h00500093);
    chk("redir_pc_out", {24'd0, pc_out}, 32'h40);

    // redirect in OUT together with dec_ready
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h80;
    tick();
    dec_ready = 1'b0; redirect_valid = 1'b0;
    chk("redir_out_valid", {31'd0, dec_valid}, 32'd0);
    chk("redir_out_count", {16'd0, instr_count}, 32'd8);
    chk("redir_out_addr", {24'd0, imem_addr}, 32'h80);

    // reset while presenting
    fetch(32'h402081B3);
    chk("pre_rst_valid", {31'd0, dec_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("mid_rst_count", {16'd0, instr_count}, 32'd0);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_rd", {27'd0, rd}, 32'd0);
    tick();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", {24'd0, imem_addr}, 32'h00);

    // redirect straight out of IDLE
    rst = 1'b1;
    tick();
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect_valid = 1'b0;
    chk("idle_redir_addr", {24'd0, imem_addr}, 32'h20);
    fetch(32'h00500093);
    chk("idle_redir_pc_out", {24'd0, pc_out}, 32'h20);
    accept();
    chk("idle_redir_next", {24'd0, imem_addr}, 32'h24);

    // PC wrap on the main DUT
    redirect_valid = 1'b1; redirect_pc = 8'hFC;
    tick();
    redirect_valid = 1'b0;
    fetch(32'h00500093);
    accept();
    chk("wrap_addr", {24'd0, imem_addr}, 32'h00);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
